// File: rtl/mem_arbiter.sv
// Round-robin arbiter sharing the memory line port between I-cache refills and
// D-cache refills/write-backs, with grant and conflict counters.
module mem_arbiter #(
  parameter int unsigned ADDR_W = 32,
  parameter int unsigned LINE_W = 128
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              ic_valid_i,
  input  logic [ADDR_W-1:0] ic_addr_i,
  output logic [LINE_W-1:0] ic_rdata_o,
  output logic              ic_ready_o,
  input  logic              dc_valid_i,
  input  logic              dc_rw_i,
  input  logic [ADDR_W-1:0] dc_addr_i,
  input  logic [LINE_W-1:0] dc_wdata_i,
  output logic [LINE_W-1:0] dc_rdata_o,
  output logic              dc_ready_o,
  output logic              mem_valid_o,
  output logic              mem_rw_o,
  output logic [ADDR_W-1:0] mem_addr_o,
  output logic [LINE_W-1:0] mem_wdata_o,
  input  logic [LINE_W-1:0] mem_rdata_i,
  input  logic              mem_ready_i,
  output logic              busy_o,
  output logic [31:0]       gnt_ic_cnt_o,
  output logic [31:0]       gnt_dc_cnt_o,
  output logic [31:0]       conflict_cnt_o
);

  typedef enum logic [2:0] {StIdle, StServeI, StServeD, StRespI, StRespD} state_e;

  state_e state_q, state_d;
  logic   last_d_q;  // 1 when the most recent grant went to the D-cache
  logic   gnt_i, gnt_d;

  logic              req_rw_q;
  logic [ADDR_W-1:0] req_addr_q;
  logic [LINE_W-1:0] req_wdata_q;
  logic [LINE_W-1:0] ic_rdata_q, dc_rdata_q;
  logic [31:0]       gnt_ic_q, gnt_dc_q, conflict_q;

  always_comb begin
    state_d = state_q;
    gnt_i   = 1'b0;
    gnt_d   = 1'b0;
    unique case (state_q)
      StIdle: begin
        // On a tie the requester that did not win last time goes first.
        if (dc_valid_i && (!ic_valid_i || !last_d_q)) begin
          gnt_d   = 1'b1;
          state_d = StServeD;
        end else if (ic_valid_i) begin
          gnt_i   = 1'b1;
          state_d = StServeI;
        end
      end
      StServeI: if (mem_ready_i) state_d = StRespI;
      StServeD: if (mem_ready_i) state_d = StRespD;
      StRespI, StRespD: state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q  <= StIdle;
      last_d_q <= 1'b0;
    end else begin
      state_q <= state_d;
      if (gnt_i || gnt_d) last_d_q <= gnt_d;
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      req_rw_q    <= 1'b0;
      req_addr_q  <= '0;
      req_wdata_q <= '0;
    end else if (gnt_d) begin
      req_rw_q    <= dc_rw_i;
      req_addr_q  <= dc_addr_i;
      req_wdata_q <= dc_wdata_i;
    end else if (gnt_i) begin
      req_rw_q    <= 1'b0;
      req_addr_q  <= ic_addr_i;
      req_wdata_q <= '0;
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      ic_rdata_q <= '0;
      dc_rdata_q <= '0;
    end else begin
      if (state_q == StServeI && mem_ready_i) ic_rdata_q <= mem_rdata_i;
      if (state_q == StServeD && mem_ready_i) dc_rdata_q <= mem_rdata_i;
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      gnt_ic_q   <= '0;
      gnt_dc_q   <= '0;
      conflict_q <= '0;
    end else begin
      if (gnt_i) gnt_ic_q <= gnt_ic_q + 32'd1;
      if (gnt_d) gnt_dc_q <= gnt_dc_q + 32'd1;
      if (state_q == StIdle && ic_valid_i && dc_valid_i) conflict_q <= conflict_q + 32'd1;
    end
  end

  assign mem_valid_o    = (state_q == StServeI) || (state_q == StServeD);
  assign mem_rw_o       = req_rw_q;
  assign mem_addr_o     = req_addr_q;
  assign mem_wdata_o    = req_wdata_q;
  assign ic_ready_o     = (state_q == StRespI);
  assign dc_ready_o     = (state_q == StRespD);
  assign ic_rdata_o     = ic_rdata_q;
  assign dc_rdata_o     = dc_rdata_q;
  assign busy_o         = (state_q != StIdle);
  assign gnt_ic_cnt_o   = gnt_ic_q;
  assign gnt_dc_cnt_o   = gnt_dc_q;
  assign conflict_cnt_o = conflict_q;

endmodule

// File: tb/tb_mem_arbiter.sv
// Self-checking bench for mem_arbiter: directed scenarios plus a randomized run
// checked against a transaction-level round-robin model.
module tb_mem_arbiter;

  logic         clk, rst;
  logic         ic_valid, ic_ready, dc_valid, dc_rw, dc_ready;
  logic [31:0]  ic_addr, dc_addr, mem_addr;
  logic [127:0] ic_rdata, dc_rdata, dc_wdata, mem_wdata, mem_rdata;
  logic         mem_valid, mem_rw, mem_ready, busy;
  logic [31:0]  gnt_ic_cnt, gnt_dc_cnt, conflict_cnt;

  int n_cmp  = 0;
  int n_fail = 0;

  typedef struct packed {
    logic         mv, busy, rw;
    logic [31:0]  addr, addr_late;
    logic [127:0] wdata;
    logic         ir, dr;
    logic [127:0] ird, drd;
    logic         mv_resp, ir2, dr2;
  } obs_t;

  mem_arbiter #(.ADDR_W(32), .LINE_W(128)) dut (
    .clk_i(clk), .rst_i(rst),
    .ic_valid_i(ic_valid), .ic_addr_i(ic_addr), .ic_rdata_o(ic_rdata), .ic_ready_o(ic_ready),
    .dc_valid_i(dc_valid), .dc_rw_i(dc_rw), .dc_addr_i(dc_addr), .dc_wdata_i(dc_wdata),
    .dc_rdata_o(dc_rdata), .dc_ready_o(dc_ready),
    .mem_valid_o(mem_valid), .mem_rw_o(mem_rw), .mem_addr_o(mem_addr),
    .mem_wdata_o(mem_wdata), .mem_rdata_i(mem_rdata), .mem_ready_i(mem_ready),
    .busy_o(busy), .gnt_ic_cnt_o(gnt_ic_cnt), .gnt_dc_cnt_o(gnt_dc_cnt),
    .conflict_cnt_o(conflict_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [127:0] rnd128();
    return {$urandom(), $urandom(), $urandom(), $urandom()};
  endfunction

  task automatic do_reset();
    rst = 1'b1; ic_valid = 1'b0; dc_valid = 1'b0; dc_rw = 1'b0; mem_ready = 1'b0;
    ic_addr = '0; dc_addr = '0; dc_wdata = '0; mem_rdata = '0;
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
  endtask

  // Called at a negedge in an IDLE cycle with requests already driven; plays the
  // memory side for one transaction and returns at the negedge of the next IDLE cycle.
  task automatic run_txn(input int lat, input logic [127:0] rd, input logic chg,
                         input logic rearm, output obs_t o);
    @(negedge clk);
    o.mv = mem_valid; o.busy = busy; o.rw = mem_rw; o.addr = mem_addr; o.wdata = mem_wdata;
    if (chg) dc_addr = dc_addr ^ 32'hFFFF_0000;
    if (rearm) begin ic_valid = 1'b1; dc_valid = 1'b1; end
    for (int i = 0; i < lat; i++) begin
      mem_ready = 1'b0;
      @(negedge clk);
    end
    o.addr_late = mem_addr;
    mem_ready = 1'b1; mem_rdata = rd;
    @(negedge clk);
    o.ir = ic_ready; o.dr = dc_ready; o.ird = ic_rdata; o.drd = dc_rdata; o.mv_resp = mem_valid;
    if (ic_ready) ic_valid = 1'b0;
    if (dc_ready) dc_valid = 1'b0;
    mem_ready = 1'($urandom_range(0, 1)); mem_rdata = rnd128();
    @(negedge clk);
    o.ir2 = ic_ready; o.dr2 = dc_ready;
    mem_ready = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1; ic_valid = 1'b1; dc_valid = 1'b1; mem_ready = 1'b1;
    @(negedge clk);
    @(negedge clk);
    n_cmp++; if ({mem_valid, mem_rw, mem_addr, mem_wdata, busy, ic_ready, dc_ready} !== '0) begin
      n_fail++; $display("FAIL reset_outputs got mv=%b rw=%b addr=%h busy=%b want all 0",
                         mem_valid, mem_rw, mem_addr, busy); end
    n_cmp++; if ({ic_rdata, dc_rdata} !== '0) begin
      n_fail++; $display("FAIL reset_rdata got %h/%h want 0", ic_rdata, dc_rdata); end
    n_cmp++; if ({gnt_ic_cnt, gnt_dc_cnt, conflict_cnt} !== 96'd0) begin
      n_fail++; $display("FAIL reset_counters got %0d/%0d/%0d want 0/0/0",
                         gnt_ic_cnt, gnt_dc_cnt, conflict_cnt); end
    do_reset();
  endtask

  task automatic test_ic_refill();
    obs_t o;
    do_reset();
    ic_valid = 1'b1; ic_addr = 32'h0000_0040;
    run_txn(4, {16{8'hA5}}, 1'b0, 1'b0, o);
    n_cmp++; if ({o.mv, o.busy, o.rw, o.addr} !== {3'b110, 32'h40}) begin
      n_fail++; $display("FAIL ic_request got mv=%b busy=%b rw=%b addr=%h want 1 1 0 00000040",
                         o.mv, o.busy, o.rw, o.addr); end
    n_cmp++; if ({o.ir, o.dr, o.ir2, o.mv_resp} !== 4'b1000) begin
      n_fail++; $display("FAIL ic_ready_pulse got ir=%b dr=%b ir_next=%b mv=%b want 1 0 0 0",
                         o.ir, o.dr, o.ir2, o.mv_resp); end
    n_cmp++; if (o.ird !== {16{8'hA5}}) begin
      n_fail++; $display("FAIL ic_rdata got %h want a5..a5", o.ird); end
    n_cmp++; if ({gnt_ic_cnt, gnt_dc_cnt} !== {32'd1, 32'd0}) begin
      n_fail++; $display("FAIL ic_gnt_cnt got %0d/%0d want 1/0", gnt_ic_cnt, gnt_dc_cnt); end
  endtask

  task automatic test_dc_writeback();
    obs_t o;
    logic [127:0] wd;
    wd = 128'h1234_5678_9ABC_DEF0_0FED_CBA9_8765_4321;
    do_reset();
    dc_valid = 1'b1; dc_rw = 1'b1; dc_addr = 32'h0000_1000; dc_wdata = wd;
    run_txn(2, rnd128(), 1'b0, 1'b0, o);
    n_cmp++; if ({o.mv, o.rw, o.addr} !== {2'b11, 32'h1000}) begin
      n_fail++; $display("FAIL wb_request got mv=%b rw=%b addr=%h want 1 1 00001000",
                         o.mv, o.rw, o.addr); end
    n_cmp++; if (o.wdata !== wd) begin
      n_fail++; $display("FAIL wb_wdata got %h want %h", o.wdata, wd); end
    n_cmp++; if ({o.dr, o.ir, o.dr2, o.ir2} !== 4'b1000) begin
      n_fail++; $display("FAIL wb_ready got dr=%b ir=%b dr_next=%b ir_next=%b want 1 0 0 0",
                         o.dr, o.ir, o.dr2, o.ir2); end
    n_cmp++; if ({gnt_ic_cnt, gnt_dc_cnt} !== {32'd0, 32'd1}) begin
      n_fail++; $display("FAIL wb_gnt_cnt got %0d/%0d want 0/1", gnt_ic_cnt, gnt_dc_cnt); end
  endtask

  task automatic test_tie_from_reset();
    obs_t o1, o2;
    logic [127:0] rda, rdb;
    rda = rnd128(); rdb = rnd128();
    do_reset();
    ic_valid = 1'b1; ic_addr = 32'h100; dc_valid = 1'b1; dc_rw = 1'b0; dc_addr = 32'h200;
    run_txn(1, rda, 1'b0, 1'b0, o1);
    run_txn(0, rdb, 1'b0, 1'b0, o2);
    n_cmp++; if ({o1.dr, o1.ir, o1.addr} !== {2'b10, 32'h200}) begin
      n_fail++; $display("FAIL tie_first got dr=%b ir=%b addr=%h want D at 00000200",
                         o1.dr, o1.ir, o1.addr); end
    n_cmp++; if ({o2.ir, o2.dr, o2.addr} !== {2'b10, 32'h100}) begin
      n_fail++; $display("FAIL tie_second got ir=%b dr=%b addr=%h want I at 00000100",
                         o2.ir, o2.dr, o2.addr); end
    n_cmp++; if ({o1.drd, o2.ird, dc_rdata} !== {rda, rdb, rda}) begin
      n_fail++; $display("FAIL tie_rdata got d=%h i=%h d_hold=%h want %h %h %h",
                         o1.drd, o2.ird, dc_rdata, rda, rdb, rda); end
    n_cmp++; if ({gnt_ic_cnt, gnt_dc_cnt, conflict_cnt} !== {32'd1, 32'd1, 32'd1}) begin
      n_fail++; $display("FAIL tie_counters got %0d/%0d/%0d want 1/1/1",
                         gnt_ic_cnt, gnt_dc_cnt, conflict_cnt); end
  endtask

  task automatic test_contention();
    obs_t o;
    logic [31:0] want;
    do_reset();
    ic_valid = 1'b1; ic_addr = 32'h100; dc_valid = 1'b1; dc_rw = 1'b0; dc_addr = 32'h200;
    for (int k = 0; k < 4; k++) begin
      want = (k % 2 == 0) ? 32'h200 : 32'h100;
      run_txn(1, rnd128(), 1'b0, 1'b1, o);
      n_cmp++; if (o.addr !== want) begin
        n_fail++; $display("FAIL contention_order txn=%0d got addr=%h want %h", k, o.addr, want);
      end
    end
    n_cmp++; if ({gnt_ic_cnt, gnt_dc_cnt} !== {32'd2, 32'd2}) begin
      n_fail++; $display("FAIL contention_cnt got %0d/%0d want 2/2", gnt_ic_cnt, gnt_dc_cnt); end
  endtask

  task automatic test_addr_change();
    obs_t o;
    do_reset();
    dc_valid = 1'b1; dc_rw = 1'b0; dc_addr = 32'h0000_ABC0;
    run_txn(3, rnd128(), 1'b1, 1'b0, o);
    n_cmp++; if ({o.addr, o.addr_late} !== {32'hABC0, 32'hABC0}) begin
      n_fail++; $display("FAIL addr_change got %h then %h want 0000abc0 both",
                         o.addr, o.addr_late); end
  endtask

  task automatic test_reset_mid();
    obs_t o;
    logic seen;
    do_reset();
    dc_valid = 1'b1; dc_rw = 1'b0; dc_addr = 32'h3000;
    @(negedge clk);
    n_cmp++; if (mem_valid !== 1'b1) begin
      n_fail++; $display("FAIL rstmid_serving got mv=%b want 1", mem_valid); end
    rst = 1'b1;
    #1;
    n_cmp++; if ({mem_valid, busy, mem_addr} !== '0) begin
      n_fail++; $display("FAIL rstmid_drop got mv=%b busy=%b addr=%h want 0",
                         mem_valid, busy, mem_addr); end
    n_cmp++; if ({gnt_ic_cnt, gnt_dc_cnt, conflict_cnt} !== 96'd0) begin
      n_fail++; $display("FAIL rstmid_counters got %0d/%0d/%0d want 0",
                         gnt_ic_cnt, gnt_dc_cnt, conflict_cnt); end
    seen = dc_ready | ic_ready;
    dc_valid = 1'b0; mem_ready = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      seen = seen | dc_ready | ic_ready;
    end
    n_cmp++; if (seen !== 1'b0) begin
      n_fail++; $display("FAIL rstmid_no_ready got pulse=%b want 0", seen); end
    mem_ready = 1'b0;
    ic_valid = 1'b1; ic_addr = 32'h10; dc_valid = 1'b1; dc_addr = 32'h20;
    run_txn(0, rnd128(), 1'b0, 1'b0, o);
    n_cmp++; if ({o.dr, o.addr, conflict_cnt} !== {1'b1, 32'h20, 32'd1}) begin
      n_fail++; $display("FAIL rstmid_tie got dr=%b addr=%h conf=%0d want 1 00000020 1",
                         o.dr, o.addr, conflict_cnt); end
  endtask

  task automatic test_random();
    obs_t o;
    logic         exp_d, m_last_d, blk_i, blk_d, chg, e_rw;
    logic [31:0]  m_gi, m_gd, m_cf, e_addr;
    logic [127:0] e_wd, rd;
    int           lat;
    do_reset();
    m_last_d = 1'b0; m_gi = '0; m_gd = '0; m_cf = '0; blk_i = 1'b0; blk_d = 1'b0;
    for (int it = 0; it < 300; it++) begin
      if (!ic_valid && !blk_i && $urandom_range(0, 2) != 0) begin
        ic_valid = 1'b1; ic_addr = $urandom();
      end
      if (!dc_valid && !blk_d && $urandom_range(0, 2) != 0) begin
        dc_valid = 1'b1; dc_rw = 1'($urandom_range(0, 1)); dc_addr = $urandom();
        dc_wdata = rnd128();
      end
      mem_ready = 1'($urandom_range(0, 1));
      blk_i = 1'b0; blk_d = 1'b0;
      if (!ic_valid && !dc_valid) begin
        @(negedge clk);
        n_cmp++; if ({mem_valid, busy} !== 2'b00) begin
          n_fail++; $display("FAIL rnd_idle it=%0d got mv=%b busy=%b want 0 0",
                             it, mem_valid, busy); end
        continue;
      end
      if (ic_valid && dc_valid) begin
        m_cf   = m_cf + 32'd1;
        exp_d  = !m_last_d;
      end else begin
        exp_d  = dc_valid;
      end
      m_last_d = exp_d;
      if (exp_d) m_gd = m_gd + 32'd1;
      else       m_gi = m_gi + 32'd1;
      e_addr = exp_d ? dc_addr : ic_addr;
      e_rw   = exp_d ? dc_rw : 1'b0;
      e_wd   = exp_d ? dc_wdata : 128'd0;
      lat    = int'($urandom_range(0, 3));
      rd     = rnd128();
      chg    = exp_d && (lat > 0) && ($urandom_range(0, 1) == 1);
      run_txn(lat, rd, chg, 1'b0, o);
      n_cmp++; if ({o.mv, o.busy, o.rw, o.addr, o.addr_late} !== {2'b11, e_rw, e_addr, e_addr})
      begin
        n_fail++; $display("FAIL rnd_req it=%0d got mv=%b busy=%b rw=%b addr=%h/%h want 1 1 %b %h",
                           it, o.mv, o.busy, o.rw, o.addr, o.addr_late, e_rw, e_addr); end
      n_cmp++; if (o.wdata !== e_wd) begin
        n_fail++; $display("FAIL rnd_wdata it=%0d got %h want %h", it, o.wdata, e_wd); end
      n_cmp++; if ({o.ir, o.dr, o.ir2, o.dr2, o.mv_resp} !== {~exp_d, exp_d, 3'b000}) begin
        n_fail++; $display("FAIL rnd_ready it=%0d got ir=%b dr=%b next=%b%b mv=%b want D=%b",
                           it, o.ir, o.dr, o.ir2, o.dr2, o.mv_resp, exp_d); end
      if (!e_rw) begin
        n_cmp++; if ((exp_d ? o.drd : o.ird) !== rd) begin
          n_fail++; $display("FAIL rnd_rdata it=%0d got %h want %h",
                             it, exp_d ? o.drd : o.ird, rd); end
      end
      n_cmp++; if ({gnt_ic_cnt, gnt_dc_cnt, conflict_cnt} !== {m_gi, m_gd, m_cf}) begin
        n_fail++; $display("FAIL rnd_counters it=%0d got %0d/%0d/%0d want %0d/%0d/%0d", it,
                           gnt_ic_cnt, gnt_dc_cnt, conflict_cnt, m_gi, m_gd, m_cf); end
      if (exp_d) begin dc_valid = 1'b0; blk_d = 1'b1; end
      else       begin ic_valid = 1'b0; blk_i = 1'b1; end
    end
  endtask

  initial begin
    rst = 1'b1; ic_valid = 1'b0; dc_valid = 1'b0; dc_rw = 1'b0; mem_ready = 1'b0;
    ic_addr = '0; dc_addr = '0; dc_wdata = '0; mem_rdata = '0;
    test_reset();
    test_ic_refill();
    test_dc_writeback();
    test_tie_from_reset();
    test_contention();
    test_addr_change();
    test_reset_mid();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
